imc_result_collector: RTL and testbench

// Return path of the IMC array controller. Captures the digital sense outputs (CSA1/CSA2 bits and
// ADC1/ADC2 codes) produced after READ_RRAM / MAC_OPERATION issue. Tags each result with op type
// and column, and queues it in an output buffer the wishbone host drains. Sits beside the

---
 rtl/imc_pkg.sv | 47 ++++
 rtl/result_fifo.sv | 83 ++++++++
 rtl/imc_result_collector.sv | 222 ++++++++++++++++++++++
 tb/tb_imc_result_collector.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imc_pkg.sv
// ---------------------------------------------------------------------------
// imc_pkg
// Shared definitions for the IMC result collector:
//   - result tags written into the top nibble of every output-buffer entry
//   - bit offsets of the entry fields
//   - collector FSM state encoding
//   - pack_entry(): builds one 32-bit output-buffer entry
// Entry layout: [31:28] tag, [27:24] column, [23:16] sequence, [15:8] zero,
//               [7:0] data.
// ---------------------------------------------------------------------------
package imc_pkg;

   localparam int ENTRY_W = 32;

   // Result tags
   localparam logic [3:0] TAG_READ    = 4'h1;
   localparam logic [3:0] TAG_MAC     = 4'h2;
   localparam logic [3:0] TAG_TIMEOUT = 4'hF;

   // Entry field offsets (LSB of each field)
   localparam int TAG_LSB  = 28;
   localparam int COL_LSB  = 24;
   localparam int SEQ_LSB  = 16;
   localparam int DATA_LSB = 0;

   // Collector FSM states
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_READ_WAIT = 2'd1;
   localparam logic [1:0] ST_READ_CAP  = 2'd2;
   localparam logic [1:0] ST_MAC_WAIT  = 2'd3;

   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic [3:0] tag,
      input logic [3:0] col,
      input logic [7:0] seq,
      input logic [7:0] data
   );
      logic [ENTRY_W-1:0] e;
      e                      = '0;
      e[TAG_LSB  +: 4]       = tag;
      e[COL_LSB  +: 4]       = col;
      e[SEQ_LSB  +: 8]       = seq;
      e[DATA_LSB +: 8]       = data;
      return e;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
// Synchronous FIFO with a registered read port and count-based flags.
// A pop loads the head entry into rd_data_o on the same edge, so the popped
// word is visible the cycle after rd_en_i. A write while full is accepted only
// if a pop happens on the same edge; otherwise it is dropped and drop_o is
// raised for that cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr_en_i      write request
//   wr_data_i    write word
//   rd_en_i      pop request (ignored when empty)
//   rd_data_o    last popped word (0 after reset)
//   empty_o      count == 0
//   full_o       count == 2**ADDR_SIZE
//   drop_o       write request rejected because the FIFO is full
// ---------------------------------------------------------------------------
module result_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_SIZE  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  drop_o
);

   localparam int DEPTH = 2 ** ADDR_SIZE;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_SIZE-1:0]  wr_ptr_q;
   logic [ADDR_SIZE-1:0]  rd_ptr_q;
   logic [ADDR_SIZE:0]    count_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  do_wr;
   logic                  do_rd;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (ADDR_SIZE + 1)'(DEPTH));
   assign do_rd     = rd_en_i & ~empty_o;
   // A pop on the same edge frees the slot the write needs.
   assign do_wr     = wr_en_i & (~full_o | do_rd);
   assign drop_o    = wr_en_i & ~do_wr;
   assign rd_data_o = rd_data_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_rd) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_data_q <= mem_q[rd_ptr_q];
         end
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the storage array has no reset; pointers and count define which
   // words are valid, so resetting it would only cost area and routing.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/imc_result_collector.sv
// ---------------------------------------------------------------------------
// imc_result_collector
// Return path of the IMC array controller. Waits for the sense result of each
// READ / MAC issued by the decoder, tags it with op type, column and sequence
// number, and queues it in an output buffer drained by the wishbone host.
// Columns below the midpoint are served by CSA1/ADC1, the upper half by
// CSA2/ADC2; the other channel is ignored. A wait longer than TIMEOUT cycles
// queues a TIMEOUT entry for the current column and moves on.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   op_start, op_is_mac           op-issue strobe and its type (1 = MAC)
//   op_col_start, op_col_end      READ column / MAC first and last column
//   SAEN_CSA1, SAEN_CSA2          sense-amp enables
//   csa1_out, csa2_out            latched CSA decisions
//   adc1_valid/data, adc2_valid/data  ADC conversion strobes and codes
//   wishbone_rd_en_output_buffer  host pop request
//   clear_err                     clears the sticky error flags
//   wishbone_databus_out          last popped entry (registered)
//   wishbone_empty_output_buffer  buffer empty
//   wishbone_full_output_buffer   buffer full
//   busy                          FSM not idle
//   overflow_err                  sticky: entry dropped on a full buffer
//   protocol_err                  sticky: op_start while busy or bad MAC range
// ---------------------------------------------------------------------------
module imc_result_collector
   import imc_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADC_BITS     = 8,
   parameter int ARRAY_DEPTH  = 4,
   parameter int ADDR_SIZE_OB = 4,
   parameter int TIMEOUT      = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   op_start,
   input  logic                   op_is_mac,
   input  logic [ARRAY_DEPTH-1:0] op_col_start,
   input  logic [ARRAY_DEPTH-1:0] op_col_end,
   input  logic                   SAEN_CSA1,
   input  logic                   SAEN_CSA2,
   input  logic                   csa1_out,
   input  logic                   csa2_out,
   input  logic                   adc1_valid,
   input  logic                   adc2_valid,
   input  logic [ADC_BITS-1:0]    adc1_data,
   input  logic [ADC_BITS-1:0]    adc2_data,
   input  logic                   wishbone_rd_en_output_buffer,
   input  logic                   clear_err,
   output logic [DATA_WIDTH-1:0]  wishbone_databus_out,
   output logic                   wishbone_empty_output_buffer,
   output logic                   wishbone_full_output_buffer,
   output logic                   busy,
   output logic                   overflow_err,
   output logic                   protocol_err
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   // First column served by the second channel.
   localparam logic [ARRAY_DEPTH-1:0] CH2_COL = ARRAY_DEPTH'(2 ** (ARRAY_DEPTH - 1));

   logic [1:0]             state_q, state_d;
   logic [ARRAY_DEPTH-1:0] col_q, col_d;
   logic [ARRAY_DEPTH-1:0] end_q, end_d;
   logic [7:0]             seq_q, seq_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic                   push_q, push_d;
   logic [DATA_WIDTH-1:0]  push_data_q, push_data_d;
   logic                   overflow_err_q;
   logic                   protocol_err_q;
   logic                   protocol_set;
   logic                   fifo_drop;

   // Channel routing for the column currently being served.
   logic                   use_ch2;
   logic                   saen_sel;
   logic                   csa_sel;
   logic                   adc_valid_sel;
   logic [ADC_BITS-1:0]    adc_data_sel;
   logic                   tmo_hit;

   assign use_ch2       = (col_q >= CH2_COL);
   assign saen_sel      = use_ch2 ? SAEN_CSA2  : SAEN_CSA1;
   assign csa_sel       = use_ch2 ? csa2_out   : csa1_out;
   assign adc_valid_sel = use_ch2 ? adc2_valid : adc1_valid;
   assign adc_data_sel  = use_ch2 ? adc2_data  : adc1_data;
   // The counter restarts at 0 on entry; the TIMEOUT-th waiting edge fires.
   assign tmo_hit       = (tmo_q == TMO_W'(TIMEOUT - 1));

   // NOTE: every signal driven here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      end_d        = end_q;
      seq_d        = seq_q;
      tmo_d        = tmo_q + 1'b1;
      push_d       = 1'b0;
      push_data_d  = push_data_q;
      protocol_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (op_start) begin
               col_d = op_col_start;
               end_d = op_col_end;
               seq_d = '0;
               if (!op_is_mac) begin
                  state_d = ST_READ_WAIT;
               end else if (op_col_end >= op_col_start) begin
                  state_d = ST_MAC_WAIT;
               end else begin
                  protocol_set = 1'b1;
               end
            end
         end

         ST_READ_WAIT: begin
            if (saen_sel) begin
               state_d = ST_READ_CAP;
               tmo_d   = '0;
            end else if (tmo_hit) begin
               push_d      = 1'b1;
               push_data_d = DATA_WIDTH'(pack_entry(TAG_TIMEOUT, 4'(col_q), seq_q, 8'h00));
               state_d     = ST_IDLE;
               tmo_d       = '0;
            end
         end

         // CSA decision is sampled one cycle after the enable was seen.
         ST_READ_CAP: begin
            push_d      = 1'b1;
            push_data_d = DATA_WIDTH'(pack_entry(TAG_READ, 4'(col_q), seq_q, {7'b0, csa_sel}));
            state_d     = ST_IDLE;
            tmo_d       = '0;
         end

         ST_MAC_WAIT: begin
            if (adc_valid_sel || tmo_hit) begin
               push_d      = 1'b1;
               push_data_d = adc_valid_sel
                  ? DATA_WIDTH'(pack_entry(TAG_MAC, 4'(col_q), seq_q, 8'(adc_data_sel)))
                  : DATA_WIDTH'(pack_entry(TAG_TIMEOUT, 4'(col_q), seq_q, 8'h00));
               tmo_d       = '0;
               seq_d       = seq_q + 1'b1;
               if (col_q == end_q) begin
                  state_d = ST_IDLE;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new op while one is in flight is rejected; the current op is untouched.
      if (op_start && (state_q != ST_IDLE)) begin
         protocol_set = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         col_q          <= '0;
         end_q          <= '0;
         seq_q          <= '0;
         tmo_q          <= '0;
         push_q         <= 1'b0;
         push_data_q    <= '0;
         overflow_err_q <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         end_q       <= end_d;
         seq_q       <= seq_d;
         tmo_q       <= tmo_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;

         // A new error outranks a simultaneous clear.
         if (fifo_drop) begin
            overflow_err_q <= 1'b1;
         end else if (clear_err) begin
            overflow_err_q <= 1'b0;
         end

         if (protocol_set) begin
            protocol_err_q <= 1'b1;
         end else if (clear_err) begin
            protocol_err_q <= 1'b0;
         end
      end
   end

   // The packed entry is registered once before the write, so it becomes
   // visible to the host one cycle after the capture edge.
   result_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_SIZE  (ADDR_SIZE_OB)
   ) u_result_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (push_q),
      .wr_data_i (push_data_q),
      .rd_en_i   (wishbone_rd_en_output_buffer),
      .rd_data_o (wishbone_databus_out),
      .empty_o   (wishbone_empty_output_buffer),
      .full_o    (wishbone_full_output_buffer),
      .drop_o    (fifo_drop)
   );

   assign busy         = (state_q != ST_IDLE);
   assign overflow_err = overflow_err_q;
   assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_imc_result_collector.sv
// ---------------------------------------------------------------------------
// tb_imc_result_collector
// Self-checking bench: a table of READ vectors with literal expected entries,
// hand-written sequences for MAC ordering, timeout, overflow, protocol errors
// and reset, then randomized READ/MAC traffic checked against a queue of
// entries computed from the op parameters.
// ---------------------------------------------------------------------------
module tb_imc_result_collector;

   logic        clk;
   logic        rst;
   logic        op_start;
   logic        op_is_mac;
   logic [3:0]  op_col_start;
   logic [3:0]  op_col_end;
   logic        SAEN_CSA1;
   logic        SAEN_CSA2;
   logic        csa1_out;
   logic        csa2_out;
   logic        adc1_valid;
   logic        adc2_valid;
   logic [7:0]  adc1_data;
   logic [7:0]  adc2_data;
   logic        rd_en;
   logic        clear_err;
   logic [31:0] dbus;
   logic        ob_empty;
   logic        ob_full;
   logic        busy;
   logic        overflow_err;
   logic        protocol_err;

   imc_result_collector dut (
      .clk                          (clk),
      .rst                          (rst),
      .op_start                     (op_start),
      .op_is_mac                    (op_is_mac),
      .op_col_start                 (op_col_start),
      .op_col_end                   (op_col_end),
      .SAEN_CSA1                    (SAEN_CSA1),
      .SAEN_CSA2                    (SAEN_CSA2),
      .csa1_out                     (csa1_out),
      .csa2_out                     (csa2_out),
      .adc1_valid                   (adc1_valid),
      .adc2_valid                   (adc2_valid),
      .adc1_data                    (adc1_data),
      .adc2_data                    (adc2_data),
      .wishbone_rd_en_output_buffer (rd_en),
      .clear_err                    (clear_err),
      .wishbone_databus_out         (dbus),
      .wishbone_empty_output_buffer (ob_empty),
      .wishbone_full_output_buffer  (ob_full),
      .busy                         (busy),
      .overflow_err                 (overflow_err),
      .protocol_err                 (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  mac_codes [16];

   typedef struct {
      int          col;
      bit          csa;
      logic [31:0] exp;
   } rd_vec_t;

   rd_vec_t rd_tab [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Entry value straight from the documented field layout.
   function automatic logic [31:0] entry(input int tag, input int col, input int seq, input int data);
      return 32'((tag << 28) | (col << 24) | (seq << 16) | data);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues a READ and supplies the routed CSA result. Returns right after the
   // capture edge; the entry reaches the buffer on the following edge.
   task automatic read_op(input int col, input bit csa, input bit decoy);
      op_start     = 1'b1;
      op_is_mac    = 1'b0;
      op_col_start = 4'(col);
      op_col_end   = 4'($urandom);
      tick();
      op_start = 1'b0;
      if (decoy) begin
         // Activity on the unrouted channel must not complete the read.
         if (col < 8) begin SAEN_CSA2 = 1'b1; csa2_out = ~csa; end
         else         begin SAEN_CSA1 = 1'b1; csa1_out = ~csa; end
         tick();
         tick();
         check("read_decoy_busy", busy, 1);
         SAEN_CSA1 = 1'b0;
         SAEN_CSA2 = 1'b0;
      end
      if (col < 8) begin SAEN_CSA1 = 1'b1; csa1_out = csa; end
      else         begin SAEN_CSA2 = 1'b1; csa2_out = csa; end
      tick();
      tick();
      SAEN_CSA1 = 1'b0;
      SAEN_CSA2 = 1'b0;
      check("read_busy_drop", busy, 0);
   endtask

   // Issues a MAC over s..e using mac_codes[col], with random gaps (and junk
   // strobes on the unrouted channel) between results.
   task automatic mac_op(input int s, input int e, input int max_gap);
      op_start     = 1'b1;
      op_is_mac    = 1'b1;
      op_col_start = 4'(s);
      op_col_end   = 4'(e);
      tick();
      op_start = 1'b0;
      for (int c = s; c <= e; c++) begin
         int gap;
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            if (c < 8) begin adc2_valid = 1'($urandom); adc2_data = 8'($urandom); end
            else       begin adc1_valid = 1'($urandom); adc1_data = 8'($urandom); end
            tick();
            adc1_valid = 1'b0;
            adc2_valid = 1'b0;
         end
         if (c < 8) begin adc1_valid = 1'b1; adc1_data = mac_codes[c]; end
         else       begin adc2_valid = 1'b1; adc2_data = mac_codes[c]; end
         tick();
         adc1_valid = 1'b0;
         adc2_valid = 1'b0;
      end
   endtask

   task automatic pop_check(input string name, input logic [31:0] exp);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check(name, dbus, exp);
   endtask

   // Pops until empty (bounded) and compares against the expected queue.
   task automatic drain(input string name);
      int n_exp;
      int n_got;
      n_exp = exp_q.size();
      n_got = 0;
      for (int i = 0; i < 20; i++) begin
         if (ob_empty) break;
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         n_got++;
         if (exp_q.size() > 0) check(name, dbus, exp_q.pop_front());
      end
      check({name, "_count"}, n_got, n_exp);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k_empty;
      int k_idle;

      rst          = 1'b1;
      op_start     = 1'b0;
      op_is_mac    = 1'b0;
      op_col_start = '0;
      op_col_end   = '0;
      SAEN_CSA1    = 1'b0;
      SAEN_CSA2    = 1'b0;
      csa1_out     = 1'b0;
      csa2_out     = 1'b0;
      adc1_valid   = 1'b0;
      adc2_valid   = 1'b0;
      adc1_data    = '0;
      adc2_data    = '0;
      rd_en        = 1'b0;
      clear_err    = 1'b0;

      rd_tab[0] = '{3,  1'b1, 32'h1300_0001};
      rd_tab[1] = '{10, 1'b0, 32'h1A00_0000};
      rd_tab[2] = '{7,  1'b0, 32'h1700_0000};
      rd_tab[3] = '{8,  1'b1, 32'h1800_0001};
      rd_tab[4] = '{0,  1'b1, 32'h1000_0001};
      rd_tab[5] = '{15, 1'b1, 32'h1F00_0001};

      // Reset state
      tick();
      tick();
      check("rst_dbus", dbus, 0);
      check("rst_empty", ob_empty, 1);
      check("rst_full", ob_full, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow_err, 0);
      check("rst_protocol", protocol_err, 0);
      rst = 1'b0;
      tick();

      // READ vectors: routing, CSA capture, push latency, pop
      for (int i = 0; i < 6; i++) begin
         read_op(rd_tab[i].col, rd_tab[i].csa, 1'b1);
         check("read_push_latency", ob_empty, 1);
         tick();
         check("read_visible", ob_empty, 0);
         pop_check("read_entry", rd_tab[i].exp);
         check("read_empty_after_pop", ob_empty, 1);
      end

      // MAC 6..9 across the channel boundary
      mac_codes[6] = 8'h11;
      mac_codes[7] = 8'h22;
      mac_codes[8] = 8'h33;
      mac_codes[9] = 8'h44;
      mac_op(6, 9, 3);
      check("mac_busy_drop", busy, 0);
      tick();
      tick();
      exp_q.push_back(32'h2600_0011);
      exp_q.push_back(32'h2701_0022);
      exp_q.push_back(32'h2802_0033);
      exp_q.push_back(32'h2903_0044);
      drain("mac_6_9");

      // MAC 2..3 with no routed results: two timeout entries. ADC2 strobes
      // throughout must be ignored.
      op_start     = 1'b1;
      op_is_mac    = 1'b1;
      op_col_start = 4'd2;
      op_col_end   = 4'd3;
      tick();
      op_start   = 1'b0;
      adc2_valid = 1'b1;
      adc2_data  = 8'h55;
      k_empty    = -1;
      k_idle     = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k_empty < 0 && !ob_empty) k_empty = k;
         if (k_idle < 0 && !busy) k_idle = k;
         if (k_empty >= 0 && k_idle >= 0) break;
      end
      adc2_valid = 1'b0;
      check("tmo_first_visible_cycle", k_empty, 16);
      check("tmo_idle_cycle", k_idle, 30);
      tick();
      tick();
      exp_q.push_back(32'hF200_0000);
      exp_q.push_back(32'hF301_0000);
      drain("tmo_entries");

      // Fill to 16, overflow on the 17th, clear, then push+pop while full
      for (int i = 0; i < 16; i++) begin
         read_op(i, 1'(i & 1), 1'b0);
         tick();
         exp_q.push_back(entry(1, i, 0, i & 1));
      end
      check("fill_full", ob_full, 1);
      check("fill_no_overflow", overflow_err, 0);
      read_op(5, 1'b1, 1'b0);
      tick();
      check("ovf_flag", overflow_err, 1);
      check("ovf_full", ob_full, 1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("ovf_cleared", overflow_err, 0);
      read_op(12, 1'b1, 1'b0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("pushpop_head", dbus, exp_q.pop_front());
      check("pushpop_full", ob_full, 1);
      check("pushpop_no_overflow", overflow_err, 0);
      exp_q.push_back(entry(1, 12, 0, 1));
      drain("fill_drain");
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("pop_empty_holds", dbus, 32'h1C00_0001);
      check("pop_empty_empty", ob_empty, 1);

      // op_start during MAC_WAIT: flagged, MAC completes untouched
      op_start     = 1'b1;
      op_is_mac    = 1'b1;
      op_col_start = 4'd0;
      op_col_end   = 4'd3;
      tick();
      op_is_mac    = 1'b0;
      op_col_start = 4'd9;
      tick();
      op_start = 1'b0;
      check("busy_start_protocol", protocol_err, 1);
      check("busy_start_still_busy", busy, 1);
      for (int c = 0; c < 4; c++) begin
         adc1_valid = 1'b1;
         adc1_data  = 8'(8'hA0 + c);
         tick();
         exp_q.push_back(entry(2, c, c, 8'hA0 + c));
      end
      adc1_valid = 1'b0;
      check("busy_start_done", busy, 0);
      tick();
      tick();
      drain("busy_start_entries");
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check("protocol_cleared", protocol_err, 0);

      // MAC with end < start: error, no state change, nothing queued
      op_start     = 1'b1;
      op_is_mac    = 1'b1;
      op_col_start = 4'd5;
      op_col_end   = 4'd2;
      tick();
      op_start = 1'b0;
      check("bad_range_protocol", protocol_err, 1);
      check("bad_range_idle", busy, 0);
      tick();
      tick();
      check("bad_range_empty", ob_empty, 1);

      // New error coinciding with clear_err: error wins
      clear_err = 1'b1;
      op_start  = 1'b1;
      tick();
      op_start  = 1'b0;
      check("clear_vs_error", protocol_err, 1);
      tick();
      clear_err = 1'b0;
      check("clear_alone", protocol_err, 0);

      // Reset mid-MAC with one entry buffered
      op_start     = 1'b1;
      op_is_mac    = 1'b1;
      op_col_start = 4'd0;
      op_col_end   = 4'd5;
      tick();
      op_start   = 1'b0;
      adc1_valid = 1'b1;
      adc1_data  = 8'h77;
      tick();
      adc1_valid = 1'b0;
      tick();
      tick();
      check("prerst_not_empty", ob_empty, 0);
      check("prerst_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_empty", ob_empty, 1);
      check("rst_mid_busy", busy, 0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_mid_dbus", dbus, 0);

      // Randomized READ / MAC traffic against the entry model
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(1, 0) == 0) begin
            int col;
            bit csa;
            col = int'($urandom_range(15, 0));
            csa = 1'($urandom);
            read_op(col, csa, 1'($urandom));
            exp_q.push_back(entry(1, col, 0, int'(csa)));
         end else begin
            int s;
            int e;
            s = int'($urandom_range(15, 0));
            e = s + int'($urandom_range((15 - s) < 5 ? (15 - s) : 5, 0));
            for (int c = 0; c < 16; c++) mac_codes[c] = 8'($urandom);
            mac_op(s, e, 6);
            for (int c = s; c <= e; c++) exp_q.push_back(entry(2, c, c - s, int'(mac_codes[c])));
         end
         tick();
         tick();
         check("rand_idle", busy, 0);
         drain("rand_entry");
      end
      check("final_overflow", overflow_err, 0);
      check("final_protocol", protocol_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
